netdma_write_master: RTL and testbench

Responder end of the netdma master_control/master_response interface on the RX path. It accepts one Avalon-ST packet per descriptor from the MAC-side stream and writes it word-by-word to memory over an Avalon-MM write master. It returns eop, error and bytecount to the write control, which generates the rx report. Instantiated once, beside the write-mode control block inside the netdma dispatcher.

---
 rtl/netdma_pkg.sv | 45 ++++
 rtl/netdma_write_master_fsm.sv | 96 +++++++++
 rtl/netdma_write_master.sv | 138 +++++++++++++
 tb/tb_netdma_write_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/netdma_pkg.sv
// Shared types for the netdma dispatcher: flow-control codes, descriptor and
// master_control/master_response bundles, write-master FSM states.
package netdma_pkg;

  typedef enum logic [1:0] {
    FC_IDLE   = 2'd0,
    FC_RUN    = 2'd1,
    FC_REPORT = 2'd2,
    FC_FETCH  = 2'd3
  } flow_control_t;

  typedef enum logic [1:0] {
    WM_IDLE  = 2'd0,
    WM_WRITE = 2'd1,
    WM_DRAIN = 2'd2,
    WM_DONE  = 2'd3
  } wm_state_t;

  typedef struct packed {
    logic go;
  } control_field_t;

  typedef struct packed {
    logic [31:0]    write_address;
    logic [15:0]    length;
    control_field_t control_field;
  } descriptor_t;

  typedef struct packed {
    descriptor_t   descriptor;
    flow_control_t flow_control;
  } master_control_t;

  typedef struct packed {
    logic        eop;
    logic        error;
    logic [15:0] bytecount;
  } master_response_t;

  // Unused high bytes on the eop beat map to cleared high enables.
  function automatic logic [3:0] empty2be(input logic [1:0] empty);
    return 4'hF >> empty;
  endfunction

endpackage

// File: rtl/netdma_write_master_fsm.sv
// Control FSM of the RX write master: state sequencing plus the stream-ready
// and response-eop decodes. The datapath lives in the top module.
module netdma_write_master_fsm
  import netdma_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      run_i,
  input  logic      go_i,
  input  logic      st_valid_i,
  input  logic      st_eop_i,
  input  logic      overflow_i,
  input  logic      mm_write_i,
  input  logic      mm_waitrequest_i,
  output wm_state_t state_o,
  output logic      st_ready_o,
  output logic      resp_eop_o,
  output logic      load_desc_o
);

  wm_state_t state_q, state_d;
  logic      eop_pend_q, eop_pend_d;
  logic      wr_busy;
  logic      beat;

  assign wr_busy = mm_write_i && mm_waitrequest_i;
  assign beat    = st_valid_i && st_ready_o;
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= WM_IDLE;
      eop_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      eop_pend_q <= eop_pend_d;
    end
  end

  // eop_pend marks "eop beat written, waiting for the slave to take it".
  always_comb begin
    state_d    = state_q;
    eop_pend_d = eop_pend_q;
    case (state_q)
      WM_IDLE: begin
        if (run_i && go_i) begin
          state_d    = WM_WRITE;
          eop_pend_d = 1'b0;
        end
      end
      WM_WRITE: begin
        if (!run_i) begin
          if (!wr_busy) begin
            state_d    = WM_IDLE;
            eop_pend_d = 1'b0;
          end
        end else if (eop_pend_q) begin
          if (!wr_busy) begin
            state_d    = WM_DONE;
            eop_pend_d = 1'b0;
          end
        end else if (beat && st_eop_i) begin
          if (overflow_i) state_d = WM_DONE;
          else            eop_pend_d = 1'b1;
        end else if (beat && overflow_i) begin
          state_d = WM_DRAIN;
        end
      end
      WM_DRAIN: begin
        if (!run_i) begin
          if (!wr_busy) state_d = WM_IDLE;
        end else if (beat && st_eop_i) begin
          state_d = WM_DONE;
        end
      end
      WM_DONE: begin
        if (!run_i) state_d = WM_IDLE;
      end
      default: state_d = WM_IDLE;
    endcase
  end

  always_comb begin
    st_ready_o  = 1'b0;
    resp_eop_o  = 1'b0;
    load_desc_o = 1'b0;
    case (state_q)
      WM_IDLE:  load_desc_o = run_i && go_i;
      WM_WRITE: st_ready_o  = run_i && !eop_pend_q && !wr_busy;
      WM_DRAIN: st_ready_o  = run_i;
      WM_DONE:  resp_eop_o  = 1'b1;
      default:  st_ready_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/netdma_write_master.sv
// RX write master: takes one Avalon-ST packet per descriptor and writes it to
// memory through a one-deep Avalon-MM write register, reporting eop/error/bytecount.
module netdma_write_master
  import netdma_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  master_control_t       master_control_i,
  output master_response_t      master_response_o,
  input  logic [DATA_W-1:0]     st_data_i,
  input  logic                  st_valid_i,
  input  logic                  st_sop_i,
  input  logic                  st_eop_i,
  input  logic [EMPTY_W-1:0]    st_empty_i,
  output logic                  st_ready_o,
  output logic [31:0]           mm_address_o,
  output logic [DATA_W-1:0]     mm_writedata_o,
  output logic [DATA_W/8-1:0]   mm_byteenable_o,
  output logic                  mm_write_o,
  input  logic                  mm_waitrequest_i,
  output logic [1:0]            state_o
);

  wm_state_t           state;
  logic                run, go, load_desc, resp_eop;
  logic                beat, write_beat, wr_ack, sop_err, overflow;
  logic [2:0]          beat_bytes;
  logic [16:0]         sum;

  logic [31:0]         addr_q, addr_d;
  logic [31:0]         mm_address_q, mm_address_d;
  logic [DATA_W-1:0]   mm_writedata_q, mm_writedata_d;
  logic [DATA_W/8-1:0] mm_be_q, mm_be_d;
  logic                mm_write_q, mm_write_d;
  logic [15:0]         length_q, length_d;
  logic [15:0]         bytecount_q, bytecount_d;
  logic                error_q, error_d;
  logic                first_q, first_d;

  assign run = (master_control_i.flow_control == FC_RUN);
  assign go  = master_control_i.descriptor.control_field.go;

  netdma_write_master_fsm u_fsm (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .run_i            (run),
    .go_i             (go),
    .st_valid_i       (st_valid_i),
    .st_eop_i         (st_eop_i),
    .overflow_i       (overflow),
    .mm_write_i       (mm_write_q),
    .mm_waitrequest_i (mm_waitrequest_i),
    .state_o          (state),
    .st_ready_o       (st_ready_o),
    .resp_eop_o       (resp_eop),
    .load_desc_o      (load_desc)
  );

  assign beat       = st_valid_i && st_ready_o;
  assign write_beat = beat && (state == WM_WRITE);
  assign wr_ack     = mm_write_q && !mm_waitrequest_i;
  assign sop_err    = first_q ? !st_sop_i : st_sop_i;
  assign beat_bytes = st_eop_i ? (3'd4 - 3'(st_empty_i)) : 3'd4;
  // 17-bit sum so a count near 16'hFFFF is compared without wrapping.
  assign sum        = {1'b0, bytecount_q} + {14'd0, beat_bytes};
  assign overflow   = sum > {1'b0, length_q};

  always_comb begin
    addr_d         = addr_q;
    mm_address_d   = mm_address_q;
    mm_writedata_d = mm_writedata_q;
    mm_be_d        = mm_be_q;
    mm_write_d     = mm_write_q;
    length_d       = length_q;
    bytecount_d    = bytecount_q;
    error_d        = error_q;
    first_d        = first_q;

    if (wr_ack) mm_write_d = 1'b0;

    if (load_desc) begin
      addr_d      = master_control_i.descriptor.write_address & 32'hFFFF_FFFC;
      length_d    = master_control_i.descriptor.length;
      bytecount_d = 16'd0;
      error_d     = 1'b0;
      first_d     = 1'b1;
    end else if (write_beat) begin
      first_d = 1'b0;
      if (sop_err) error_d = 1'b1;
      if (overflow) begin
        error_d     = 1'b1;
        bytecount_d = length_q;
      end else begin
        bytecount_d    = sum[15:0];
        mm_address_d   = addr_q;
        addr_d         = addr_q + 32'd4;
        mm_writedata_d = st_data_i;
        mm_be_d        = st_eop_i ? empty2be(st_empty_i) : '1;
        mm_write_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q         <= '0;
      mm_address_q   <= '0;
      mm_writedata_q <= '0;
      mm_be_q        <= '0;
      mm_write_q     <= 1'b0;
      length_q       <= '0;
      bytecount_q    <= '0;
      error_q        <= 1'b0;
      first_q        <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      mm_address_q   <= mm_address_d;
      mm_writedata_q <= mm_writedata_d;
      mm_be_q        <= mm_be_d;
      mm_write_q     <= mm_write_d;
      length_q       <= length_d;
      bytecount_q    <= bytecount_d;
      error_q        <= error_d;
      first_q        <= first_d;
    end
  end

  assign mm_address_o      = mm_address_q;
  assign mm_writedata_o    = mm_writedata_q;
  assign mm_byteenable_o   = mm_be_q;
  assign mm_write_o        = mm_write_q;
  assign state_o           = state;
  assign master_response_o = '{eop: resp_eop, error: error_q, bytecount: bytecount_q};

endmodule

// File: tb/tb_netdma_write_master.sv
// Scoreboard bench for netdma_write_master: directed packets push expected
// writes; a monitor pops and compares each accepted Avalon-MM write.
module tb_netdma_write_master;
  import netdma_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  master_control_t  mc;
  master_response_t resp;
  logic [31:0]      st_data;
  logic             st_valid, st_sop, st_eop, st_ready;
  logic [1:0]       st_empty;
  logic [31:0]      mm_address, mm_writedata;
  logic [3:0]       mm_be;
  logic             mm_write;
  logic             mm_waitreq = 1'b0;
  logic [1:0]       state;

  always #5 clk = ~clk;

  netdma_write_master #(.DATA_W(32), .EMPTY_W(2)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .master_control_i  (mc),
    .master_response_o (resp),
    .st_data_i         (st_data),
    .st_valid_i        (st_valid),
    .st_sop_i          (st_sop),
    .st_eop_i          (st_eop),
    .st_empty_i        (st_empty),
    .st_ready_o        (st_ready),
    .mm_address_o      (mm_address),
    .mm_writedata_o    (mm_writedata),
    .mm_byteenable_o   (mm_be),
    .mm_write_o        (mm_write),
    .mm_waitrequest_i  (mm_waitreq),
    .state_o           (state)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          stall_n = 0;
  int          stall_cnt = 0;
  int          wr_cycles = 0;
  bit          eop_seen = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: every new write is stalled stall_n cycles before acceptance.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mm_waitreq = 1'b0;
      stall_cnt  = 0;
    end else if (mm_write && stall_cnt < stall_n) begin
      mm_waitreq = 1'b1;
      stall_cnt++;
    end else begin
      mm_waitreq = 1'b0;
      stall_cnt  = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (resp.eop) eop_seen = 1;
      if (mm_write) wr_cycles++;
      if (prev_stall) begin
        chk("stall_write", 32'(mm_write), 32'd1);
        chk("stall_addr", mm_address, prev_addr);
        chk("stall_data", mm_writedata, prev_data);
        chk("stall_be", 32'(mm_be), 32'(prev_be));
      end
      if (mm_write && !mm_waitreq) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   mm_address, mm_writedata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", mm_address, mon_e.addr);
          chk("wr_data", mm_writedata, mon_e.data);
          chk("wr_be", 32'(mm_be), 32'(mon_e.be));
          $display("write addr=0x%08h data=0x%08h be=0x%h", mm_address, mm_writedata, mm_be);
        end
      end
      prev_stall = mm_write && mm_waitreq;
      prev_addr  = mm_address;
      prev_data  = mm_writedata;
      prev_be    = mm_be;
    end
  end

  task automatic start_desc(input logic [31:0] addr, input logic [15:0] len);
    @(posedge clk); #1;
    mc.descriptor.write_address     = addr;
    mc.descriptor.length            = len;
    mc.descriptor.control_field.go  = 1'b1;
    mc.flow_control                 = FC_RUN;
    eop_seen                        = 0;
    @(posedge clk); #1;
    mc.descriptor.control_field.go  = 1'b0;
    chk("start_state", 32'(state), 32'(WM_WRITE));
  endtask

  task automatic drive_beat(input logic [31:0] data, input bit sop, input bit eop,
                            input logic [1:0] empty, output bit ok);
    st_data  = data;
    st_sop   = sop;
    st_eop   = eop;
    st_empty = empty;
    st_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (st_ready) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      errors++;
      $display("FAIL beat_timeout: got ready=0 for 200 cycles, expected ready=1");
    end
  endtask

  task automatic send_pkt(input int pkt, input int n, input int last_empty, input bit bad_sop,
                          input logic [31:0] base, input int len);
    int          cnt = 0;
    int          w = 0;
    int          bytes;
    bit          ovf = 0;
    bit          ok;
    bit          last;
    logic [31:0] data;
    logic [3:0]  be;
    for (int i = 0; i < n; i++) begin
      last  = (i == n - 1);
      bytes = last ? 4 - last_empty : 4;
      data  = 32'hD000_0000 + 32'(pkt << 16) + 32'(i);
      be    = 4'hF;
      if (last) begin
        case (last_empty)
          1:       be = 4'h7;
          2:       be = 4'h3;
          3:       be = 4'h1;
          default: be = 4'hF;
        endcase
      end
      if (!ovf && cnt + bytes <= len) begin
        exp_q.push_back('{addr: base + 32'(4 * w), data: data, be: be});
        cnt += bytes;
        w++;
      end else begin
        ovf = 1;
      end
      drive_beat(data, (i == 0) && !bad_sop, last, 2'(last ? last_empty : 0), ok);
      if (!ok) break;
      if (!last) chk("early_eop", 32'(resp.eop), 32'd0);
    end
    st_valid = 1'b0;
  endtask

  task automatic finish_pkt(input string tag, input int exp_bc, input bit exp_err);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (resp.eop) break;
    end
    chk({tag, "_eop"}, 32'(resp.eop), 32'd1);
    chk({tag, "_bytecount"}, 32'(resp.bytecount), 32'(exp_bc));
    chk({tag, "_error"}, 32'(resp.error), 32'(exp_err));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    mc.flow_control = FC_REPORT;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(state), 32'(WM_IDLE));
    chk({tag, "_eop_clr"}, 32'(resp.eop), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mm_write"}, 32'(mm_write), 32'd0);
    chk({tag, "_mm_address"}, mm_address, 32'd0);
    chk({tag, "_mm_writedata"}, mm_writedata, 32'd0);
    chk({tag, "_mm_be"}, 32'(mm_be), 32'd0);
    chk({tag, "_st_ready"}, 32'(st_ready), 32'd0);
    chk({tag, "_response"}, 32'(resp), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'(WM_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    mc       = '0;
    st_data  = '0;
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    st_empty = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 16-beat packet, full length, no stalls
    start_desc(32'h0000_1000, 16'd64);
    send_pkt(1, 16, 0, 0, 32'h0000_1000, 64);
    finish_pkt("full", 64, 0);

    // 3 beats, 1 valid byte on the last
    start_desc(32'h0000_1000, 16'd64);
    send_pkt(2, 3, 3, 0, 32'h0000_1000, 64);
    finish_pkt("partial", 9, 0);

    // overflow: length 8, 5 beats -> 2 writes, rest drained
    start_desc(32'h0000_1000, 16'd8);
    send_pkt(3, 5, 0, 0, 32'h0000_1000, 8);
    finish_pkt("overflow", 8, 1);

    // 3-cycle waitrequest on every write
    stall_n   = 3;
    start_desc(32'h0000_4000, 16'd64);
    wr_cycles = 0;
    send_pkt(4, 6, 0, 0, 32'h0000_4000, 64);
    finish_pkt("stall", 24, 0);
    chk("stall_cycles", 32'(wr_cycles), 32'd24);

    // abort while write 2 is stalled
    start_desc(32'h0000_5000, 16'd64);
    exp_q.push_back('{addr: 32'h0000_5000, data: 32'hD005_0000, be: 4'hF});
    exp_q.push_back('{addr: 32'h0000_5004, data: 32'hD005_0001, be: 4'hF});
    drive_beat(32'hD005_0000, 1, 0, 2'd0, ok);
    drive_beat(32'hD005_0001, 0, 0, 2'd0, ok);
    chk("abort_stalled", 32'(mm_write && mm_waitreq), 32'd1);
    mc.flow_control = FC_IDLE;
    st_data = 32'hD005_0002;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (state == WM_IDLE) break;
    end
    st_valid = 1'b0;
    chk("abort_idle", 32'(state), 32'(WM_IDLE));
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    chk("abort_no_eop", 32'(eop_seen), 32'd0);
    chk("abort_bytecount", 32'(resp.bytecount), 32'd8);
    chk("abort_error", 32'(resp.error), 32'd0);
    chk("abort_mm_write", 32'(mm_write), 32'd0);

    // asynchronous reset in the middle of a stalled write
    start_desc(32'h0000_6000, 16'd64);
    drive_beat(32'hD006_0000, 1, 0, 2'd0, ok);
    chk("rst_pre_write", 32'(mm_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    st_valid        = 1'b0;
    mc.flow_control = FC_IDLE;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    stall_n = 0;

    // first beat without sop
    start_desc(32'h0000_7000, 16'd16);
    send_pkt(6, 2, 0, 1, 32'h0000_7000, 16);
    finish_pkt("nosop", 8, 1);

    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
